// File: rtl/wb_pkg.sv
// Shared types and load-formatting helper for the writeback/commit stage.
package wb_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        rf_wen;
  } commit_rec_t;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  // Byte and halfword loads always take the low lanes of the raw word.
  function automatic logic [31:0] load_fmt(input logic [2:0] funct3, input logic [31:0] raw);
    logic [31:0] v;
    v = '0;
    case (funct3)
      LD_B:    v = {{24{raw[7]}}, raw[7:0]};
      LD_H:    v = {{16{raw[15]}}, raw[15:0]};
      LD_W:    v = raw;
      LD_BU:   v = {24'd0, raw[7:0]};
      LD_HU:   v = {16'd0, raw[15:0]};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// Trace FIFO holding commit records; the head reads zero whenever the FIFO is empty.
module commit_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_push,
  input  logic        i_pop,
  input  commit_rec_t i_data,
  output commit_rec_t o_head,
  output logic        o_full,
  output logic        o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  commit_rec_t   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_head  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: selects the writeback value, drives the register file, counts retirements.
// Define WB_COMMIT_TRACE_EN to build the commit trace FIFO; otherwise the trace ports are tied off.
module wb_commit
  import wb_pkg::*;
#(
  parameter int TRACE_DEPTH = 4,
  parameter int INSTRET_W   = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid_wb,
  output logic                 ready_last,
  input  logic [31:0]          pc_wb,
  input  logic [31:0]          rdata_wb_raw,
  input  logic [2:0]           funct3_wb,
  input  logic [3:0]           csr_wen_wb,
  input  logic [31:0]          Ex_result_wb,
  input  logic [31:0]          rd_value_wb,
  input  logic [4:0]           rd_wb,
  input  logic                 mem_ren_wb,
  input  logic                 R_wen_wb,
  input  logic                 jump_flag_wb,
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [INSTRET_W-1:0] instret,
  output logic                 trace_valid,
  input  logic                 trace_ready,
  output logic [31:0]          trace_pc,
  output logic [4:0]           trace_rd,
  output logic [31:0]          trace_wdata,
  output logic                 trace_rf_wen
);

  logic                 w_ready;
  logic                 w_commit;
  logic                 w_rf_wen;
  logic [31:0]          w_wb_value;
  logic [INSTRET_W-1:0] r_instret;

  // Link and CSR-old values take priority over load data, which beats the ALU result.
  always_comb begin
    w_wb_value = Ex_result_wb;
    if (jump_flag_wb | (|csr_wen_wb)) w_wb_value = rd_value_wb;
    else if (mem_ren_wb)              w_wb_value = load_fmt(funct3_wb, rdata_wb_raw);
  end

  assign w_commit   = valid_wb & w_ready;
  assign w_rf_wen   = R_wen_wb & (rd_wb != 5'd0);
  assign ready_last = w_ready;
  assign rf_wen     = reset & w_commit & w_rf_wen;
  assign rf_waddr   = rd_wb;
  assign rf_wdata   = w_wb_value;
  assign instret    = r_instret;

  always_ff @(posedge clock) begin
    if (!reset)        r_instret <= '0;
    else if (w_commit) r_instret <= r_instret + INSTRET_W'(1);
  end

`ifdef WB_COMMIT_TRACE_EN
  commit_rec_t w_push_rec;
  commit_rec_t w_head;
  logic        w_full;
  logic        w_empty;

  assign w_push_rec = {pc_wb, rd_wb, w_wb_value, w_rf_wen};

  commit_fifo #(.DEPTH(TRACE_DEPTH)) u_fifo (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_push    (w_commit),
    .i_pop     (trace_ready),
    .i_data    (w_push_rec),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // A full FIFO can still accept when the consumer frees the head this cycle.
  assign w_ready      = ~w_full | trace_ready;
  assign trace_valid  = ~w_empty;
  assign trace_pc     = w_head.pc;
  assign trace_rd     = w_head.rd;
  assign trace_wdata  = w_head.wdata;
  assign trace_rf_wen = w_head.rf_wen;
`else
  logic w_unused_trace;

  assign w_unused_trace = ^{trace_ready, pc_wb};
  assign w_ready        = 1'b1;
  assign trace_valid    = 1'b0;
  assign trace_pc       = '0;
  assign trace_rd       = '0;
  assign trace_wdata    = '0;
  assign trace_rf_wen   = 1'b0;
`endif

endmodule
